// File: rtl/gfsk_demodulator.sv
// GFSK demodulator: hysteresis zero-crossing detector, half-period
// measurement, tone classification, debounce and carrier-lock tracking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOST  | no carrier; the next crossing starts a fresh measurement
// ST_ACQ   | one crossing seen; the next crossing gives a full interval
// ST_LOCK  | carrier present; every crossing issues a decision
module gfsk_demodulator #(
  parameter int HYST      = 8,
  parameter int PERIOD_TH = 24,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int DEBOUNCE  = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       ad_data,
  input  logic             ad_valid,
  output logic             data_out,
  output logic             data_valid,
  output logic             dec_raw,
  output logic [CNT_W-1:0] half_len,
  output logic             locked
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);

  // Thresholds are widened to 9 bits so 128+HYST cannot wrap.
  localparam logic [8:0]       HI_TH  = 9'(128 + HYST);
  localparam logic [8:0]       LO_TH  = 9'(127 - HYST);
  localparam logic [CNT_W:0]   TO_EXT = (CNT_W + 1)'(TIMEOUT);
  localparam logic [CNT_W:0]   TH_EXT = (CNT_W + 1)'(PERIOD_TH);
  localparam logic [RUN_W-1:0] DEB    = RUN_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_LOST = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             sign;
  logic             sign_new;
  logic             crossing;
  logic             timeout_hit;
  logic             issue_dec;
  logic             dec_bit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] half_len_int;
  logic [CNT_W:0]   cnt_inc;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;
  logic             cand;
  logic             cand_next;
  logic             data_out_next;

  // Sign tracking with hysteresis, crossing detect and half-period counting
  always_comb begin
    sign_new = sign;
    if ({1'b0, ad_data} >= HI_TH) begin
      sign_new = 1'b1;
    end else if ({1'b0, ad_data} <= LO_TH) begin
      sign_new = 1'b0;
    end

    crossing     = ad_valid && (sign_new != sign);
    cnt_inc      = {1'b0, cnt} + (CNT_W + 1)'(1);
    half_len_int = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    // A crossing takes priority over a coincident timeout.
    timeout_hit  = ad_valid && !crossing && (cnt_inc >= TO_EXT);

    if (crossing) begin
      cnt_next = '0;
    end else if (cnt_inc >= TO_EXT) begin
      cnt_next = TO_EXT[CNT_W-1:0];
    end else begin
      cnt_next = cnt_inc[CNT_W-1:0];
    end

    dec_bit = ({1'b0, half_len_int} > TH_EXT);
  end

  // Lock state next-state logic; the LOST->ACQ interval is partial, so no decision
  always_comb begin
    state_next = state;
    issue_dec  = 1'b0;
    if (crossing) begin
      case (state)
        ST_LOST: state_next = ST_ACQ;
        default: begin
          state_next = ST_LOCK;
          issue_dec  = 1'b1;
        end
      endcase
    end else if (timeout_hit) begin
      state_next = ST_LOST;
    end
  end

  // Debounce: data_out follows the candidate once it has repeated DEBOUNCE times
  always_comb begin
    cand_next     = cand;
    run_next      = run;
    data_out_next = data_out;
    if (issue_dec) begin
      if (dec_bit == cand) begin
        run_next = (run >= DEB) ? DEB : run + RUN_W'(1);
      end else begin
        cand_next = dec_bit;
        run_next  = RUN_W'(1);
      end
      if (run_next == DEB) begin
        data_out_next = cand_next;
      end
    end else if (timeout_hit) begin
      cand_next = 1'b0;
      run_next  = '0;
    end
  end

  // Lock state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= ST_LOST;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers; everything except the valid pulse holds while ad_valid is low
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sign       <= 1'b0;
      cnt        <= '0;
      run        <= '0;
      cand       <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      dec_raw    <= 1'b0;
      half_len   <= '0;
    end else begin
      data_valid <= issue_dec;
      if (ad_valid) begin
        sign     <= sign_new;
        cnt      <= cnt_next;
        run      <= run_next;
        cand     <= cand_next;
        data_out <= data_out_next;
        if (issue_dec) begin
          dec_raw  <= dec_bit;
          half_len <= half_len_int;
        end
      end
    end
  end

  assign locked = (state == ST_LOCK);

endmodule

// File: tb/tb_gfsk_demodulator.sv
// Self-checking bench for gfsk_demodulator: segment table plus hand-written
// sequences for hysteresis, timeout, gated samples and mid-stream reset.
module tb_gfsk_demodulator;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] ad_data;
  logic       ad_valid;
  logic       data_out;
  logic       data_valid;
  logic       dec_raw;
  logic [7:0] half_len;
  logic       locked;

  int checks   = 0;
  int failures = 0;

  gfsk_demodulator #(
    .HYST(8), .PERIOD_TH(24), .CNT_W(8), .TIMEOUT(255), .DEBOUNCE(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ad_data   (ad_data),
    .ad_valid  (ad_valid),
    .data_out  (data_out),
    .data_valid(data_valid),
    .dec_raw   (dec_raw),
    .half_len  (half_len),
    .locked    (locked)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] level;
    int         len;
    logic       dv;
    logic       dec;
    logic [7:0] hl;
    logic       lk;
    logic       dout;
  } seg_t;

  seg_t segs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle; outputs are sampled 1 ns after the edge
  task automatic step(input logic [7:0] d, input logic v);
    ad_data  = d;
    ad_valid = v;
    @(posedge sys_clk);
    #1;
  endtask

  // First sample of a segment is the crossing; the rest must be quiet
  task automatic run_seg(input seg_t s, input int idx);
    int extra;
    extra = 0;
    step(s.level, 1'b1);
    chk($sformatf("seg%0d_dv", idx), data_valid, s.dv);
    if (s.dv) begin
      chk($sformatf("seg%0d_dec", idx), dec_raw, s.dec);
      chk($sformatf("seg%0d_half_len", idx), half_len, s.hl);
    end
    chk($sformatf("seg%0d_locked", idx), locked, s.lk);
    chk($sformatf("seg%0d_data_out", idx), data_out, s.dout);
    for (int i = 1; i < s.len; i++) begin
      step(s.level, 1'b1);
      if (data_valid) extra++;
    end
    chk($sformatf("seg%0d_extra_dv", idx), extra, 0);
  endtask

  initial begin
    int extra;

    segs[0] = '{8'd200, 32, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0};
    segs[1] = '{8'd56,  32, 1'b1, 1'b1, 8'd32, 1'b1, 1'b0};
    segs[2] = '{8'd200, 32, 1'b1, 1'b1, 8'd32, 1'b1, 1'b1};
    segs[3] = '{8'd56,  32, 1'b1, 1'b1, 8'd32, 1'b1, 1'b1};
    segs[4] = '{8'd200, 16, 1'b1, 1'b1, 8'd32, 1'b1, 1'b1};
    segs[5] = '{8'd56,  16, 1'b1, 1'b0, 8'd16, 1'b1, 1'b1};
    segs[6] = '{8'd200, 16, 1'b1, 1'b0, 8'd16, 1'b1, 1'b0};
    segs[7] = '{8'd56,  16, 1'b1, 1'b0, 8'd16, 1'b1, 1'b0};
    segs[8] = '{8'd200, 32, 1'b1, 1'b0, 8'd16, 1'b1, 1'b0};

    // Reset with random samples
    sys_rst_n = 1'b0;
    ad_data   = 8'd0;
    ad_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom_range(0, 255)), 1'b1);
      chk("reset_outputs", {data_out, data_valid, dec_raw, half_len, locked}, 0);
    end
    sys_rst_n = 1'b1;

    // Acquisition, bit-1 lock and tone switch
    for (int i = 0; i < 9; i++) run_seg(segs[i], i);

    // Hysteresis: dead-band samples mid half-period
    extra = 0;
    step(8'd56, 1'b1);
    chk("hyst_entry_dv", data_valid, 1);
    chk("hyst_entry_half_len", half_len, 32);
    chk("hyst_entry_dec", dec_raw, 1);
    chk("hyst_entry_data_out", data_out, 0);
    for (int i = 0; i < 9; i++) begin step(8'd56, 1'b1); if (data_valid) extra++; end
    step(8'd125, 1'b1); if (data_valid) extra++;
    step(8'd131, 1'b1); if (data_valid) extra++;
    step(8'd125, 1'b1); if (data_valid) extra++;
    for (int i = 0; i < 19; i++) begin step(8'd56, 1'b1); if (data_valid) extra++; end
    chk("hyst_extra_dv", extra, 0);
    step(8'd200, 1'b1);
    chk("hyst_dv", data_valid, 1);
    chk("hyst_half_len", half_len, 32);
    chk("hyst_data_out", data_out, 1);

    // Timeout: 255 non-crossing samples after the last crossing
    extra = 0;
    for (int i = 0; i < 254; i++) begin step(8'd200, 1'b1); if (data_valid) extra++; end
    chk("timeout_extra_dv", extra, 0);
    chk("timeout_locked_254", locked, 1);
    step(8'd200, 1'b1);
    chk("timeout_locked_255", locked, 0);
    chk("timeout_data_out_held", data_out, 1);
    for (int i = 0; i < 3; i++) step(8'd200, 1'b1);
    step(8'd56, 1'b1);
    chk("relock_first_dv", data_valid, 0);
    chk("relock_first_locked", locked, 0);
    for (int i = 0; i < 31; i++) step(8'd56, 1'b1);
    step(8'd200, 1'b1);
    chk("relock_dv", data_valid, 1);
    chk("relock_half_len", half_len, 32);
    chk("relock_dec", dec_raw, 1);
    chk("relock_locked", locked, 1);

    // Gated samples: opposite-level data on invalid cycles must be ignored
    for (int i = 0; i < 31; i++) step(8'd200, 1'b1);
    step(8'd56, 1'b1);
    chk("gated_entry_dv", data_valid, 1);
    chk("gated_entry_half_len", half_len, 32);
    extra = 0;
    for (int i = 0; i < 31; i++) begin
      step(8'd200, 1'b0); if (data_valid) extra++;
      step(8'd56, 1'b1);  if (data_valid) extra++;
    end
    step(8'd200, 1'b0); if (data_valid) extra++;
    chk("gated_extra_dv", extra, 0);
    step(8'd200, 1'b1);
    chk("gated_dv", data_valid, 1);
    chk("gated_half_len", half_len, 32);
    step(8'd56, 1'b0);
    chk("gated_dv_pulse_width", data_valid, 0);

    // Mid-stream reset restarts acquisition from LOST
    sys_rst_n = 1'b0;
    step(8'd56, 1'b1);
    chk("midreset_outputs", {data_out, data_valid, dec_raw, half_len, locked}, 0);
    sys_rst_n = 1'b1;
    step(8'd200, 1'b1);
    chk("midreset_first_dv", data_valid, 0);
    chk("midreset_first_locked", locked, 0);
    for (int i = 0; i < 31; i++) step(8'd200, 1'b1);
    step(8'd56, 1'b1);
    chk("midreset_dv", data_valid, 1);
    chk("midreset_half_len", half_len, 32);
    chk("midreset_locked", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
